// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// The open-drain clock and data lines are controlled through active-high
// pull-low enables. The receiver on the same pins should ignore line
// activity while busy is high.
//
// Ports:
//   clk, rst_n          system clock and synchronous active-low reset
//   tx_data, tx_valid   command byte and send request
//   tx_ready            high when a request can be accepted
//   ps2_clk, ps2_data   raw (asynchronous) PS/2 line levels
//   ps2_clk_drive_low   1 = pull PS/2 clock low
//   ps2_data_drive_low  1 = pull PS/2 data low
//   busy                high while a transaction is in progress
//   tx_done             one-cycle pulse at the end of every transaction
//   tx_error            one-cycle pulse with tx_done on NACK or timeout
module ps2_host_tx #(
  parameter int unsigned CLK_HZ           = 100_000_000,
  parameter int unsigned INHIBIT_US       = 100,
  parameter int unsigned START_TIMEOUT_US = 15000,
  parameter int unsigned XFER_TIMEOUT_US  = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned CYC_PER_US = CLK_HZ / 1_000_000;
  localparam int unsigned INH        = CYC_PER_US * INHIBIT_US;
  localparam int unsigned STO        = CYC_PER_US * START_TIMEOUT_US;
  localparam int unsigned XTO        = CYC_PER_US * XFER_TIMEOUT_US;
  localparam int unsigned MAX_A      = (INH > STO) ? INH : STO;
  localparam int unsigned MAX_CNT    = (MAX_A > XTO) ? MAX_A : XTO;
  localparam int unsigned TW         = $clog2(MAX_CNT + 1);

  localparam logic [TW-1:0] INH_LAST = TW'(INH - 1);
  localparam logic [TW-1:0] STO_LAST = TW'(STO - 1);
  localparam logic [TW-1:0] XTO_LAST = TW'(XTO - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    WAIT_CLK,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [7:0]    shreg, shreg_n;
  logic          parity, parity_n;
  logic [3:0]    bit_idx, bit_idx_n;
  logic          nack, nack_n;
  logic          clk_dl_n, data_dl_n, done_n, err_n;
  logic [1:0]    sync_clk, sync_data;
  logic          fall, timeout;

  // Index 0 is the newest sample, index 1 the older one.
  assign fall = sync_clk[1] && !sync_clk[0];

  assign busy = (state != IDLE);
  // The done cycle is already in IDLE; holding ready low there gives the
  // one-cycle gap before the next byte can be accepted.
  assign tx_ready = (state == IDLE) && !tx_done;

  always_comb begin
    timeout = 1'b0;
    if (state == WAIT_CLK && timer == STO_LAST)
      timeout = 1'b1;
    if ((state == SEND || state == ACK || state == WAIT_IDLE) && timer == XTO_LAST)
      timeout = 1'b1;
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    shreg_n   = shreg;
    parity_n  = parity;
    bit_idx_n = bit_idx;
    nack_n    = nack;
    clk_dl_n  = ps2_clk_drive_low;
    data_dl_n = ps2_data_drive_low;
    done_n    = 1'b0;
    err_n     = 1'b0;

    case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          shreg_n   = tx_data;
          parity_n  = ~^tx_data;
          bit_idx_n = '0;
          timer_n   = '0;
          nack_n    = 1'b0;
          clk_dl_n  = 1'b1;
          data_dl_n = 1'b0;
          state_n   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (timer == INH_LAST) begin
          clk_dl_n  = 1'b0;
          data_dl_n = 1'b1;
          timer_n   = '0;
          state_n   = WAIT_CLK;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      WAIT_CLK: begin
        timer_n = timer + 1'b1;
        if (fall) begin
          data_dl_n = ~shreg[0];
          bit_idx_n = 4'd1;
          timer_n   = '0;
          state_n   = SEND;
        end
      end
      SEND: begin
        timer_n = timer + 1'b1;
        if (fall) begin
          bit_idx_n = bit_idx + 4'd1;
          if (bit_idx == 4'd9) begin
            data_dl_n = 1'b0;
            state_n   = ACK;
          end else if (bit_idx == 4'd8) begin
            data_dl_n = ~parity;
          end else begin
            data_dl_n = ~shreg[bit_idx[2:0]];
          end
        end
      end
      ACK: begin
        timer_n = timer + 1'b1;
        if (fall) begin
          nack_n  = sync_data[1];
          state_n = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        timer_n = timer + 1'b1;
        if (sync_clk[1] && sync_data[1]) begin
          done_n  = 1'b1;
          err_n   = nack;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Timeout overrides anything a coincident fall would have done.
    if (timeout) begin
      clk_dl_n  = 1'b0;
      data_dl_n = 1'b0;
      done_n    = 1'b1;
      err_n     = 1'b1;
      timer_n   = '0;
      state_n   = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= IDLE;
      timer              <= '0;
      shreg              <= '0;
      parity             <= 1'b0;
      bit_idx            <= '0;
      nack               <= 1'b0;
      ps2_clk_drive_low  <= 1'b0;
      ps2_data_drive_low <= 1'b0;
      tx_done            <= 1'b0;
      tx_error           <= 1'b0;
      sync_clk           <= '1;
      sync_data          <= '1;
    end else begin
      state              <= state_n;
      timer              <= timer_n;
      shreg              <= shreg_n;
      parity             <= parity_n;
      bit_idx            <= bit_idx_n;
      nack               <= nack_n;
      ps2_clk_drive_low  <= clk_dl_n;
      ps2_data_drive_low <= data_dl_n;
      tx_done            <= done_n;
      tx_error           <= err_n;
      sync_clk           <= {sync_clk[0], ps2_clk};
      sync_data          <= {sync_data[0], ps2_data};
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a keyboard model that
// clocks 40-cycle periods, samples data before each clock release and ACKs
// by pulling data low for the 11th clock.
module tb_ps2_host_tx;

  localparam int unsigned INH = 100;
  localparam int unsigned STO = 15000;
  localparam int unsigned XTO = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk, ps2_data;
  logic       ps2_clk_drive_low, ps2_data_drive_low;
  logic       busy, tx_done, tx_error;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int checks = 0;
  int fails = 0;
  int cyc = 0;

  // Wired-AND open-drain bus with pull-ups.
  assign ps2_clk  = ~(ps2_clk_drive_low | dev_clk_low);
  assign ps2_data = ~(ps2_data_drive_low | dev_data_low);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_host_tx #(
    .CLK_HZ(1_000_000),
    .INHIBIT_US(100),
    .START_TIMEOUT_US(15000),
    .XFER_TIMEOUT_US(2000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .ps2_clk_drive_low(ps2_clk_drive_low),
    .ps2_data_drive_low(ps2_data_drive_low),
    .busy(busy),
    .tx_done(tx_done),
    .tx_error(tx_error)
  );

  task automatic accept(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_release(input string name);
    int n;
    n = 0;
    while (!(ps2_clk_drive_low === 1'b0 && ps2_data_drive_low === 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      fails++;
      $display("FAIL %s_rts: no request-to-send after %0d cycles, required within 3000", name, n);
    end
  endtask

  // Keyboard model: frame[0] = start, [8:1] data, [9] parity, [10] stop.
  task automatic kbd(input int pulses, input bit ack, output logic [10:0] frame);
    frame = '1;
    wait_release("kbd");
    frame[0] = ps2_data;
    repeat (10) @(negedge clk);
    for (int i = 1; i <= pulses; i++) begin
      if (i == 11 && ack) begin
        dev_data_low = 1'b1;
        repeat (5) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      if (i <= 10) frame[i] = ps2_data;
      dev_clk_low = 1'b0;
      if (i == 11) dev_data_low = 1'b0;
      else repeat (20) @(negedge clk);
    end
  endtask

  task automatic wait_done(input string name, input int limit);
    int n;
    n = 0;
    while (tx_done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= limit) begin
      fails++;
      $display("FAIL %s_done: tx_done not seen within %0d cycles", name, limit);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_ready, busy, ps2_clk_drive_low, ps2_data_drive_low, tx_done, tx_error} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_outputs: got %b, required 100000 (ready,busy,cdl,ddl,done,err)",
               {tx_ready, busy, ps2_clk_drive_low, ps2_data_drive_low, tx_done, tx_error});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_send_ed;
    int n;
    logic [10:0] frame;
    accept(8'hED);
    n = 0;
    while (ps2_clk_drive_low === 1'b1 && n < 500) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != INH) begin
      fails++;
      $display("FAIL ed_inhibit_len: clock held low %0d cycles, required %0d", n, INH);
    end
    checks++;
    if (ps2_data_drive_low !== 1'b1) begin
      fails++;
      $display("FAIL ed_start_bit: data_drive_low=%b, required 1", ps2_data_drive_low);
    end
    kbd(11, 1'b1, frame);
    checks++;
    if (frame !== 11'b1_1_11101101_0) begin
      fails++;
      $display("FAIL ed_frame: captured %b, required %b", frame, 11'b1_1_11101101_0);
    end
    wait_done("ed", 100);
    checks++;
    if (tx_error !== 1'b0 || tx_ready !== 1'b0) begin
      fails++;
      $display("FAIL ed_done_cycle: error=%b ready=%b, required error=0 ready=0", tx_error, tx_ready);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
      fails++;
      $display("FAIL ed_after_done: busy=%b ready=%b done=%b, required 0 1 0", busy, tx_ready, tx_done);
    end
  endtask

  task automatic test_send_f4;
    logic [10:0] frame;
    accept(8'hF4);
    kbd(11, 1'b1, frame);
    checks++;
    if (frame !== 11'b1_0_11110100_0) begin
      fails++;
      $display("FAIL f4_frame: captured %b, required %b", frame, 11'b1_0_11110100_0);
    end
    wait_done("f4", 100);
    checks++;
    if (tx_error !== 1'b0) begin
      fails++;
      $display("FAIL f4_error: tx_error=%b, required 0", tx_error);
    end
    @(negedge clk);
  endtask

  task automatic test_nack;
    logic [10:0] frame;
    accept(8'hFF);
    kbd(11, 1'b0, frame);
    wait_done("nack", 100);
    checks++;
    if ({tx_error, ps2_clk_drive_low, ps2_data_drive_low} !== 3'b100) begin
      fails++;
      $display("FAIL nack_done: err,cdl,ddl=%b, required 100",
               {tx_error, ps2_clk_drive_low, ps2_data_drive_low});
    end
    @(negedge clk);
  endtask

  task automatic test_start_timeout;
    int t0;
    accept(8'h55);
    wait_release("sto");
    t0 = cyc;
    wait_done("sto", 20000);
    checks++;
    if (cyc - t0 != STO) begin
      fails++;
      $display("FAIL sto_len: timeout after %0d cycles, required %0d", cyc - t0, STO);
    end
    checks++;
    if ({tx_error, ps2_clk_drive_low, ps2_data_drive_low} !== 3'b100) begin
      fails++;
      $display("FAIL sto_done: err,cdl,ddl=%b, required 100",
               {tx_error, ps2_clk_drive_low, ps2_data_drive_low});
    end
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) begin
      fails++;
      $display("FAIL sto_ready: tx_ready=%b, required 1", tx_ready);
    end
  endtask

  task automatic test_xfer_timeout;
    int t0;
    int n;
    logic [10:0] frame;
    t0 = 0;
    accept(8'hED);
    fork
      kbd(5, 1'b0, frame);
      begin
        wait_release("xto");
        n = 0;
        while (ps2_data_drive_low !== 1'b0 && n < 3000) begin
          @(negedge clk);
          n++;
        end
        t0 = cyc;
        checks++;
        if (n >= 3000) begin
          fails++;
          $display("FAIL xto_first_bit: bit 0 not driven within %0d cycles", n);
        end
      end
    join
    wait_done("xto", 3000);
    checks++;
    if (cyc - t0 != XTO) begin
      fails++;
      $display("FAIL xto_len: timeout after %0d cycles, required %0d", cyc - t0, XTO);
    end
    checks++;
    if ({tx_error, ps2_clk_drive_low, ps2_data_drive_low} !== 3'b100) begin
      fails++;
      $display("FAIL xto_done: err,cdl,ddl=%b, required 100",
               {tx_error, ps2_clk_drive_low, ps2_data_drive_low});
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL xto_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    logic [10:0] frame;
    int seen;
    accept(8'hA5);
    kbd(5, 1'b0, frame);
    // A5 bit 4 is 0, so the data line should be pulled low here.
    checks++;
    if (busy !== 1'b1 || ps2_data_drive_low !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_pre: busy=%b ddl=%b, required 1 1", busy, ps2_data_drive_low);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({ps2_clk_drive_low, ps2_data_drive_low, busy, tx_done} !== 4'b0000) begin
      fails++;
      $display("FAIL rstmid_post: cdl,ddl,busy,done=%b, required 0000",
               {ps2_clk_drive_low, ps2_data_drive_low, busy, tx_done});
    end
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx_done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      fails++;
      $display("FAIL rstmid_no_done: %0d tx_done pulses after reset, required 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] frame;
    @(negedge clk);
    tx_data  = 8'hF4;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h00;
    kbd(11, 1'b1, frame);
    checks++;
    if (frame !== 11'b1_0_11110100_0) begin
      fails++;
      $display("FAIL b2b_frame: captured %b, required %b", frame, 11'b1_0_11110100_0);
    end
    wait_done("b2b", 100);
    checks++;
    if (tx_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_ready_at_done: tx_ready=%b, required 0", tx_ready);
    end
    tx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_single: busy=%b ready=%b, required 0 1", busy, tx_ready);
    end
    accept(8'hFF);
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_second_accept: busy=%b, required 1", busy);
    end
    kbd(11, 1'b1, frame);
    checks++;
    if (frame !== 11'b1_1_11111111_0) begin
      fails++;
      $display("FAIL b2b_second_frame: captured %b, required %b", frame, 11'b1_1_11111111_0);
    end
    wait_done("b2b2", 100);
    checks++;
    if (tx_error !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second_error: tx_error=%b, required 0", tx_error);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_send_f4();
    test_nack();
    test_start_timeout();
    test_xfer_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard.
- Drives the open-drain PS/2 clock and data lines through active-high pull-low enables.
- Sits beside the PS/2 scancode receiver on the same two pins.
- While busy=1, the receiver must ignore line activity.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- INHIBIT_US, 100, duration the host holds PS/2 clock low before request-to-send.
- START_TIMEOUT_US, 15000, maximum wait from clock release to the first device falling edge.
- XFER_TIMEOUT_US, 2000, maximum time from the first falling edge to the end of ACK.

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE; a byte is accepted when tx_valid && tx_ready.
- ps2_clk  in  1  raw PS/2 clock line (asynchronous).
- ps2_data  in  1  raw PS/2 data line (asynchronous).
- ps2_clk_drive_low  out  1  1 = pull PS/2 clock low; 0 = release.
- ps2_data_drive_low  out  1  1 = pull PS/2 data low; 0 = release.
- busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse when a transaction ends, success or failure.
- tx_error  out  1  one-cycle pulse coincident with tx_done on NACK or timeout.

Behaviour:
- Synchronisation and edge detection:
  - ps2_clk and ps2_data each pass through a 2-flop synchronizer.
  - fall = sync_clk[1] && !sync_clk[0].
  - Line drive updates in the cycle after fall is detected.
- Reset (rst_n=0 at a clk edge): state=IDLE; tx_ready=1; busy=0; both drive_low=0; tx_done=0; tx_error=0; counters cleared. This applies mid-transaction too: both lines are released on the next edge.
- Derived cycle counts: INH = CLK_HZ/1e6*INHIBIT_US, STO = CLK_HZ/1e6*START_TIMEOUT_US, XTO = CLK_HZ/1e6*XFER_TIMEOUT_US. The timer is sized by $clog2 of the largest count.
- On accept: latch tx_data into shreg; parity = ~^tx_data (odd parity); bit_idx=0; go to INHIBIT.
- INHIBIT:
  - clk_drive_low=1, data_drive_low=0 for exactly INH cycles.
  - On the last cycle: data_drive_low<=1 (start bit), clk_drive_low<=0, timer<=0, go to WAIT_CLK.
- WAIT_CLK: data held low.
  - On the first fall: drive_low <= ~shreg[0], bit_idx=1, timer<=0, go to SEND.
  - If timer reaches STO before any fall: timeout.
- SEND: on each fall, drive the next bit.
  - bit_idx 1..7 → data bits 1..7.
  - bit_idx 8 → parity.
  - bit_idx 9 → release data (stop bit, drive_low=0), go to ACK.
  - Bits go out LSB first. drive_low = ~bit.
- ACK: data released. On the next fall, sample sync_data: 0 = ACK, 1 = NACK. Record the result, go to WAIT_IDLE.
- WAIT_IDLE: when sync_clk and sync_data are both 1, pulse tx_done, pulse tx_error if NACK, go to IDLE.
- Timeout:
  - The timer runs from the first fall through WAIT_IDLE; reaching XTO is a timeout.
  - On timeout in any state: both drive_low<=0, tx_done=tx_error=1 for one cycle, go to IDLE.
- Edge cases:
  - tx_valid while busy is ignored; tx_data is not re-sampled.
  - Falls during IDLE or INHIBIT are ignored (INHIBIT holds the clock low regardless).
  - A fall and a timeout on the same cycle: timeout wins.
  - Back-to-back requests: tx_ready returns 1 in the cycle after tx_done, so the minimum gap between transactions is 1 cycle.

Test Plan (CLK_HZ=1_000_000, so INH=100, STO=15000, XTO=2000; bench keyboard model toggles the clock with a 40-cycle period, samples on rising edges, ACKs after the stop bit):
- Send 0xED → ps2_clk_drive_low high for exactly 100 cycles, then start 0; model captures bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done=1, tx_error=0; busy low the next cycle.
- Send 0xF4 → captured bits 0,0,1,0,1,1,1,1, parity 0; model reports a correct frame; tx_done pulses with tx_error=0.
- Model gives NACK (leaves data high on the 11th clock) → tx_done=1 and tx_error=1 in the same cycle; both drive_low=0.
- Model never clocks → after 15000 cycles in WAIT_CLK, both lines released; tx_done=tx_error=1; tx_ready=1 the next cycle.
- Model stops after 5 clocks → timeout fires 2000 cycles after the first fall; error pulse; IDLE.
- Assert rst_n=0 during SEND bit 4 → next edge: both drive_low=0, busy=0, no tx_done. tx_valid held during busy → exactly one transaction occurs; a new byte is accepted only after tx_done.
